// File: rtl/cdb_wb_arbiter_if.sv
// Writeback bus between the functional-unit lanes and the CDB arbiter.
// The master side drives results, rob_head and flush; the slave side is the arbiter.
interface cdb_wb_arbiter_if #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_CDB       = 2,
    parameter int ROB_SIZE_CLOG = 5,
    parameter int DATA_LEN      = 32
) ();
    localparam int LN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

    logic [NUM_REQ-1:0]               res_v;
    logic [NUM_REQ*ROB_SIZE_CLOG-1:0] res_robid;
    logic [NUM_REQ*DATA_LEN-1:0]      res_data;
    logic [ROB_SIZE_CLOG-1:0]         rob_head;
    logic                             flush;
    logic [NUM_REQ-1:0]               fu_free;
    logic [NUM_CDB-1:0]               cdb_v;
    logic [NUM_CDB*ROB_SIZE_CLOG-1:0] cdb_robid;
    logic [NUM_CDB*DATA_LEN-1:0]      cdb_data;
    logic [NUM_CDB*LN_W-1:0]          cdb_lane;
    logic                             ovf_err;

    modport master (
        output res_v, res_robid, res_data, rob_head, flush,
        input  fu_free, cdb_v, cdb_robid, cdb_data, cdb_lane, ovf_err
    );

    modport slave (
        input  res_v, res_robid, res_data, rob_head, flush,
        output fu_free, cdb_v, cdb_robid, cdb_data, cdb_lane, ovf_err
    );
endinterface

// File: rtl/cdb_wb_arbiter.sv
// Per-lane skid FIFOs sharing NUM_CDB registered CDB writeback ports, round-robin granted.
// Define CDB_AGE_PRIO_EN to grant the oldest heads relative to rob_head instead.
module cdb_wb_arbiter #(
    parameter int NUM_REQ       = 4,
    parameter int NUM_CDB       = 2,
    parameter int SKID_DEPTH    = 2,
    parameter int ROB_SIZE_CLOG = 5,
    parameter int DATA_LEN      = 32
) (
    input  logic            clk,
    input  logic            rst,
    cdb_wb_arbiter_if.slave bus
);
    localparam int LN_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int PW   = (SKID_DEPTH > 1) ? $clog2(SKID_DEPTH) : 1;
    localparam int CW   = $clog2(SKID_DEPTH + 1);
    localparam int RW   = ROB_SIZE_CLOG;
    localparam int DW   = DATA_LEN;

    logic [RW-1:0]      q_robid    [NUM_REQ][SKID_DEPTH];
    logic [DW-1:0]      q_data     [NUM_REQ][SKID_DEPTH];
    logic [PW-1:0]      rd_ptr     [NUM_REQ];
    logic [PW-1:0]      wr_ptr     [NUM_REQ];
    logic [CW-1:0]      count      [NUM_REQ];
    logic [CW-1:0]      count_nxt  [NUM_REQ];
    logic [RW-1:0]      head_robid [NUM_REQ];
    logic [DW-1:0]      head_data  [NUM_REQ];
    logic [LN_W-1:0]    gnt_lane   [NUM_CDB];
    logic [NUM_CDB-1:0] gnt_v;
    logic [NUM_REQ-1:0] pop;
    logic [NUM_REQ-1:0] push_ok;
    logic [NUM_REQ-1:0] ovf_set;
    logic [LN_W-1:0]    rr_ptr;
    logic [LN_W-1:0]    rr_nxt;
    logic               any_gnt;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        if (p == PW'(SKID_DEPTH - 1))
            return '0;
        return p + PW'(1);
    endfunction

    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            head_robid[i] = q_robid[i][rd_ptr[i]];
            head_data[i]  = q_data[i][rd_ptr[i]];
        end
    end

`ifdef CDB_AGE_PRIO_EN
    logic unused_rr;
    assign unused_rr = ^rr_ptr;

    // Each port takes the smallest (robid - rob_head) among heads not yet granted; strict
    // less-than over ascending lanes breaks ties toward the lowest lane.
    always_comb begin
        logic            found;
        logic [RW-1:0]   best_age;
        logic [RW-1:0]   age;
        logic [LN_W-1:0] best;
        gnt_v    = '0;
        pop      = '0;
        any_gnt  = 1'b0;
        rr_nxt   = '0;
        found    = 1'b0;
        best_age = '0;
        age      = '0;
        best     = '0;
        for (int p = 0; p < NUM_CDB; p++) gnt_lane[p] = '0;
        for (int p = 0; p < NUM_CDB; p++) begin
            found    = 1'b0;
            best_age = '0;
            best     = '0;
            for (int i = 0; i < NUM_REQ; i++) begin
                age = head_robid[i] - bus.rob_head;
                if (count[i] != '0 && !pop[i] && (!found || age < best_age)) begin
                    found    = 1'b1;
                    best_age = age;
                    best     = LN_W'(i);
                end
            end
            if (found) begin
                gnt_v[p]    = 1'b1;
                gnt_lane[p] = best;
                pop[best]   = 1'b1;
                any_gnt     = 1'b1;
            end
        end
    end
`else
    logic unused_rob_head;
    assign unused_rob_head = ^bus.rob_head;

    always_comb begin
        int              ng;
        int              li;
        logic [LN_W-1:0] lane;
        gnt_v   = '0;
        pop     = '0;
        any_gnt = 1'b0;
        rr_nxt  = rr_ptr;
        ng      = 0;
        li      = 0;
        lane    = '0;
        for (int p = 0; p < NUM_CDB; p++) gnt_lane[p] = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            li = int'(rr_ptr) + k;
            if (li >= NUM_REQ) li = li - NUM_REQ;
            lane = LN_W'(li);
            if (count[lane] != '0 && ng < NUM_CDB) begin
                for (int p = 0; p < NUM_CDB; p++) begin
                    if (p == ng) begin
                        gnt_v[p]    = 1'b1;
                        gnt_lane[p] = lane;
                    end
                end
                pop[lane] = 1'b1;
                any_gnt   = 1'b1;
                rr_nxt    = (lane == LN_W'(NUM_REQ - 1)) ? '0 : lane + LN_W'(1);
                ng        = ng + 1;
            end
        end
    end
`endif

    // A full lane still accepts a push when its head leaves in the same cycle.
    always_comb begin
        for (int i = 0; i < NUM_REQ; i++) begin
            push_ok[i]   = bus.res_v[i] && ((count[i] < CW'(SKID_DEPTH)) || pop[i]);
            ovf_set[i]   = bus.res_v[i] && !push_ok[i];
            count_nxt[i] = count[i] + CW'(push_ok[i]) - CW'(pop[i]);
        end
    end

    always_ff @(posedge clk) begin
        for (int i = 0; i < NUM_REQ; i++) begin
            if (push_ok[i]) begin
                q_robid[i][wr_ptr[i]] <= bus.res_robid[i*RW +: RW];
                q_data[i][wr_ptr[i]]  <= bus.res_data[i*DW +: DW];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            rr_ptr        <= '0;
            bus.cdb_v     <= '0;
            bus.cdb_robid <= '0;
            bus.cdb_data  <= '0;
            bus.cdb_lane  <= '0;
            bus.fu_free   <= '1;
            bus.ovf_err   <= 1'b0;
        end else if (bus.flush) begin
            for (int i = 0; i < NUM_REQ; i++) begin
                rd_ptr[i] <= '0;
                wr_ptr[i] <= '0;
                count[i]  <= '0;
            end
            bus.cdb_v   <= '0;
            bus.fu_free <= '1;
        end else begin
            for (int i = 0; i < NUM_REQ; i++) begin
                if (push_ok[i]) wr_ptr[i] <= ptr_inc(wr_ptr[i]);
                if (pop[i])     rd_ptr[i] <= ptr_inc(rd_ptr[i]);
                count[i]       <= count_nxt[i];
                bus.fu_free[i] <= count_nxt[i] < CW'(SKID_DEPTH);
            end
            if (|ovf_set) bus.ovf_err <= 1'b1;
            for (int p = 0; p < NUM_CDB; p++) begin
                bus.cdb_v[p] <= gnt_v[p];
                if (gnt_v[p]) begin
                    bus.cdb_robid[p*RW +: RW]     <= head_robid[gnt_lane[p]];
                    bus.cdb_data[p*DW +: DW]      <= head_data[gnt_lane[p]];
                    bus.cdb_lane[p*LN_W +: LN_W]  <= gnt_lane[p];
                end
            end
            if (any_gnt) rr_ptr <= rr_nxt;
        end
    end
endmodule

// File: tb/tb_cdb_wb_arbiter.sv
// Directed bench for cdb_wb_arbiter (default parameters); expected values are hand-computed.
// Builds with or without CDB_AGE_PRIO_EN; the grant-order vector switches accordingly.
module tb_cdb_wb_arbiter;
    localparam int RW = 5;
    localparam int DW = 32;
    localparam int LW = 2;

    logic clk;
    logic rst;
    int   n_checks = 0;
    int   n_pass   = 0;

    cdb_wb_arbiter_if bus ();

    cdb_wb_arbiter dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got === exp)
            n_pass++;
        else
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    function automatic logic [31:0] dat(input int robid);
        return 32'h1000 + 32'(robid);
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.res_v = '0;
        bus.flush = 1'b0;
    endtask

    task automatic push(input int lane, input int robid, input logic [31:0] data);
        bus.res_v[lane]              = 1'b1;
        bus.res_robid[lane*RW +: RW] = RW'(robid);
        bus.res_data[lane*DW +: DW]  = data;
    endtask

    task automatic chk_port(input string tag, input int p, input logic v,
                            input int lane, input int robid, input logic [31:0] data);
        check({tag, ".v"}, 64'(bus.cdb_v[p]), 64'(v));
        if (v) begin
            check({tag, ".lane"},  64'(bus.cdb_lane[p*LW +: LW]),  64'(lane));
            check({tag, ".robid"}, 64'(bus.cdb_robid[p*RW +: RW]), 64'(robid));
            check({tag, ".data"},  64'(bus.cdb_data[p*DW +: DW]),  64'(data));
        end
    endtask

    task automatic do_reset();
        idle();
        rst = 1'b0;
        tick();
        tick();
        rst = 1'b1;
    endtask

    initial begin
        rst           = 1'b0;
        bus.res_v     = '0;
        bus.res_robid = '0;
        bus.res_data  = '0;
        bus.rob_head  = '0;
        bus.flush     = 1'b0;
        tick();
        tick();
        check("rst.cdb_v",   64'(bus.cdb_v),     64'h0);
        check("rst.robid",   64'(bus.cdb_robid), 64'h0);
        check("rst.lane",    64'(bus.cdb_lane),  64'h0);
        check("rst.fu_free", 64'(bus.fu_free),   64'hF);
        check("rst.ovf",     64'(bus.ovf_err),   64'h0);
        rst = 1'b1;

        // single push, two-cycle latency
        push(2, 5, 32'hAB);
        tick();
        idle();
        check("t1.early", 64'(bus.cdb_v), 64'h0);
        tick();
        chk_port("t1.p0", 0, 1'b1, 2, 5, 32'hAB);
        chk_port("t1.p1", 1, 1'b0, 0, 0, 0);
        tick();
        check("t1.drain", 64'(bus.cdb_v), 64'h0);

        // four lanes at once, rr_ptr from 0 and wrapping back to 0
        do_reset();
        for (int i = 0; i < 4; i++) push(i, 10 + i, dat(10 + i));
        tick();
        idle();
        tick();
        chk_port("t2.c2p0", 0, 1'b1, 0, 10, dat(10));
        chk_port("t2.c2p1", 1, 1'b1, 1, 11, dat(11));
        tick();
        chk_port("t2.c3p0", 0, 1'b1, 2, 12, dat(12));
        chk_port("t2.c3p1", 1, 1'b1, 3, 13, dat(13));
        tick();
        check("t2.drain", 64'(bus.cdb_v), 64'h0);
        push(0, 20, dat(20));
        push(3, 23, dat(23));
        tick();
        idle();
        tick();
        chk_port("t2.wrap.p0", 0, 1'b1, 0, 20, dat(20));
        chk_port("t2.wrap.p1", 1, 1'b1, 3, 23, dat(23));
        tick();

        // lane 0 pushes every cycle while lanes 1-3 hold two entries each
        do_reset();
        push(0, 1, dat(1)); push(1, 11, dat(11)); push(2, 12, dat(12)); push(3, 13, dat(13));
        tick();
        check("t3.e1.free", 64'(bus.fu_free), 64'hF);
        push(0, 2, dat(2)); push(1, 21, dat(21)); push(2, 22, dat(22)); push(3, 23, dat(23));
        tick();
        chk_port("t3.e2.p0", 0, 1'b1, 0, 1, dat(1));
        chk_port("t3.e2.p1", 1, 1'b1, 1, 11, dat(11));
        check("t3.e2.free", 64'(bus.fu_free), 64'h3);
        idle();
        push(0, 3, dat(3));
        tick();
        chk_port("t3.e3.p0", 0, 1'b1, 2, 12, dat(12));
        chk_port("t3.e3.p1", 1, 1'b1, 3, 13, dat(13));
        check("t3.e3.free", 64'(bus.fu_free), 64'hE);
        idle();
        push(0, 4, dat(4));
        tick();
        chk_port("t3.e4.p0", 0, 1'b1, 0, 2, dat(2));
        chk_port("t3.e4.p1", 1, 1'b1, 1, 21, dat(21));
        check("t3.e4.free", 64'(bus.fu_free), 64'hE);
        check("t3.e4.ovf",  64'(bus.ovf_err), 64'h0);
        push(0, 5, dat(5));
        tick();
        chk_port("t3.e5.p0", 0, 1'b1, 2, 22, dat(22));
        chk_port("t3.e5.p1", 1, 1'b1, 3, 23, dat(23));
        check("t3.e5.ovf",  64'(bus.ovf_err), 64'h1);
        check("t3.e5.free", 64'(bus.fu_free), 64'hE);
        idle();
        tick();
        chk_port("t3.e6.p0", 0, 1'b1, 0, 3, dat(3));
        chk_port("t3.e6.p1", 1, 1'b0, 0, 0, 0);
        check("t3.e6.free", 64'(bus.fu_free), 64'hF);
        tick();
        chk_port("t3.e7.p0", 0, 1'b1, 0, 4, dat(4));
        tick();
        check("t3.e8.drop", 64'(bus.cdb_v), 64'h0);

        // flush with entries queued and a same-cycle push
        for (int i = 0; i < 4; i++) push(i, 40 + i, dat(40 + i));
        tick();
        idle();
        bus.flush = 1'b1;
        push(2, 44, dat(44));
        tick();
        idle();
        check("t4.cdb_v", 64'(bus.cdb_v),   64'h0);
        check("t4.free",  64'(bus.fu_free), 64'hF);
        check("t4.ovf",   64'(bus.ovf_err), 64'h1);
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t4.quiet%0d", c), 64'(bus.cdb_v), 64'h0);
        end

        // grant order for heads 31 (lane 3), 1 (lane 0), 30 (lane 2) with rob_head = 30
        do_reset();
        check("t5.ovf_clr", 64'(bus.ovf_err), 64'h0);
        bus.rob_head = 5'd30;
        push(0, 1, dat(1));
        push(2, 30, dat(30));
        push(3, 31, dat(31));
        tick();
        idle();
        tick();
`ifdef CDB_AGE_PRIO_EN
        chk_port("t5.c2p0", 0, 1'b1, 2, 30, dat(30));
        chk_port("t5.c2p1", 1, 1'b1, 3, 31, dat(31));
        tick();
        chk_port("t5.c3p0", 0, 1'b1, 0, 1, dat(1));
        chk_port("t5.c3p1", 1, 1'b0, 0, 0, 0);
`else
        chk_port("t5.c2p0", 0, 1'b1, 0, 1, dat(1));
        chk_port("t5.c2p1", 1, 1'b1, 2, 30, dat(30));
        tick();
        chk_port("t5.c3p0", 0, 1'b1, 3, 31, dat(31));
        chk_port("t5.c3p1", 1, 1'b0, 0, 0, 0);
`endif
        tick();

        // reset mid-flight
        for (int i = 0; i < 4; i++) push(i, 50 + i, dat(50 + i));
        tick();
        idle();
        tick();
        check("t6.busy", 64'(bus.cdb_v), 64'h3);
        rst = 1'b0;
        tick();
        check("t6.cdb_v", 64'(bus.cdb_v),     64'h0);
        check("t6.robid", 64'(bus.cdb_robid), 64'h0);
        check("t6.data",  64'(bus.cdb_data),  64'h0);
        check("t6.lane",  64'(bus.cdb_lane),  64'h0);
        check("t6.free",  64'(bus.fu_free),   64'hF);
        check("t6.ovf",   64'(bus.ovf_err),   64'h0);
        rst = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            check($sformatf("t6.stale%0d", c), 64'(bus.cdb_v), 64'h0);
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
